// File: rtl/data_axi_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_axi_bridge_pkg
// Purpose  : Shared FSM state encoding and AXI attribute constants for the
//            MEM-stage data-port AXI bridge.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package data_axi_bridge_pkg;

  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_RD_ADDR = 3'd1;
  localparam state_t S_RD_DATA = 3'd2;
  localparam state_t S_WR_ADDR = 3'd3;
  localparam state_t S_WR_RESP = 3'd4;
  localparam state_t S_DONE    = 3'd5;

  localparam logic [7:0] LEN_SINGLE = 8'd0;
  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [3:0] CACHE_WB   = 4'b1111;
  localparam logic [3:0] CACHE_UC   = 4'b0000;

  function automatic logic [3:0] cache_attr(input logic cached);
    return cached ? CACHE_WB : CACHE_UC;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_axi_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : data_axi_bridge_if
// Purpose  : Single-ID AXI3/AXI4 bus bundle (AR, R, AW, W, B channels).
// Modports : master - bridge side (drives addresses, write data, readies)
//            slave  - interconnect side
// Revision : 1.0  initial release
// ============================================================================
interface data_axi_bridge_if #(
  parameter int ID_WIDTH = 4
);
  logic [ID_WIDTH-1:0] arid;
  logic [31:0]         araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [3:0]          arcache;
  logic                arvalid;
  logic                arready;

  logic [ID_WIDTH-1:0] rid;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  logic [ID_WIDTH-1:0] awid;
  logic [31:0]         awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [3:0]          awcache;
  logic                awvalid;
  logic                awready;

  logic [31:0]         wdata;
  logic [3:0]          wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_WIDTH-1:0] bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arcache, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awcache, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arcache, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awcache, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface
`default_nettype wire

// File: rtl/data_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : data_axi_bridge
// Purpose  : Converts level-held MEM-stage ren/wen requests into single-beat
//            AXI read/write transactions, one outstanding at a time, and
//            returns a one-cycle completion pulse.
// Ports    : clk, rst_n          - clock, async active-low reset
//            i_data_ren/wen      - held read/write request
//            i_data_addr/wsel/wdata, i_cached_trans - request payload
//            o_data_rdata        - last captured read data
//            o_data_rvalid/bvalid- one-cycle completion pulses
//            axi                 - AXI master bundle
// Revision : 1.0  initial release
// ============================================================================
module data_axi_bridge
  import data_axi_bridge_pkg::*;
#(
  parameter int ID_WIDTH = 4,
  parameter int DATA_ID  = 1
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        i_data_ren,
  input  wire logic        i_data_wen,
  input  wire logic [31:0] i_data_addr,
  input  wire logic [3:0]  i_data_wsel,
  input  wire logic [31:0] i_data_wdata,
  input  wire logic        i_cached_trans,
  output logic      [31:0] o_data_rdata,
  output logic             o_data_rvalid,
  output logic             o_data_bvalid,
  data_axi_bridge_if.master axi
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_is_wr;
  logic        r_discard;
  logic        r_aw_done;
  logic        r_w_done;
  logic [31:0] r_addr;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;
  logic        r_cache;
  logic [31:0] r_rdata;

  logic w_arvalid, w_rready, w_awvalid, w_wvalid, w_bready;
  logic w_data_rvalid, w_data_bvalid;

  // Response IDs/status are not used: one outstanding transaction, no retry.
  logic w_unused;
  assign w_unused = ^{axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; ren wins over wen when both are asserted.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_data_ren)      w_state_nxt = S_RD_ADDR;
        else if (i_data_wen) w_state_nxt = S_WR_ADDR;
      end
      S_RD_ADDR: if (axi.arready) w_state_nxt = S_RD_DATA;
      S_RD_DATA: if (axi.rvalid)  w_state_nxt = S_DONE;
      // A channel already done contributes its flag; otherwise its ready
      // this cycle, so same-cycle awready/wready finishes both at once.
      S_WR_ADDR: if ((r_aw_done | axi.awready) & (r_w_done | axi.wready))
                   w_state_nxt = S_WR_RESP;
      S_WR_RESP: if (axi.bvalid)  w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Request capture, per-channel write flags and withdrawal tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_wr   <= 1'b0;
      r_discard <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_addr    <= 32'd0;
      r_wstrb   <= 4'd0;
      r_wdata   <= 32'd0;
      r_cache   <= 1'b0;
      r_rdata   <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_discard <= 1'b0;
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
          if (i_data_ren | i_data_wen) begin
            r_is_wr <= ~i_data_ren;
            r_addr  <= i_data_addr;
            r_wstrb <= i_data_wsel;
            r_wdata <= i_data_wdata;
            r_cache <= i_cached_trans;
          end
        end
        S_RD_ADDR: if (!i_data_ren) r_discard <= 1'b1;
        S_RD_DATA: begin
          if (!i_data_ren) r_discard <= 1'b1;
          if (axi.rvalid)  r_rdata   <= axi.rdata;
        end
        S_WR_ADDR: begin
          if (!i_data_wen)               r_discard <= 1'b1;
          if (w_awvalid & axi.awready)   r_aw_done <= 1'b1;
          if (w_wvalid & axi.wready)     r_w_done  <= 1'b1;
        end
        S_WR_RESP: if (!i_data_wen) r_discard <= 1'b1;
        default: ;
      endcase
    end
  end

  // Output decode; all handshake outputs are pure functions of state so an
  // asynchronous reset clears them immediately.
  always_comb begin
    w_arvalid     = 1'b0;
    w_rready      = 1'b0;
    w_awvalid     = 1'b0;
    w_wvalid      = 1'b0;
    w_bready      = 1'b0;
    w_data_rvalid = 1'b0;
    w_data_bvalid = 1'b0;
    case (r_state)
      S_RD_ADDR: w_arvalid = 1'b1;
      S_RD_DATA: w_rready  = 1'b1;
      S_WR_ADDR: begin
        w_awvalid = ~r_aw_done;
        w_wvalid  = ~r_w_done;
      end
      S_WR_RESP: w_bready = 1'b1;
      S_DONE: begin
        w_data_rvalid = ~r_is_wr & ~r_discard;
        w_data_bvalid =  r_is_wr & ~r_discard;
      end
      default: ;
    endcase
  end

  assign axi.arid    = ID_WIDTH'(DATA_ID);
  assign axi.araddr  = r_addr;
  assign axi.arlen   = LEN_SINGLE;
  assign axi.arsize  = SIZE_WORD;
  assign axi.arburst = BURST_INCR;
  assign axi.arcache = cache_attr(r_cache);
  assign axi.arvalid = w_arvalid;
  assign axi.rready  = w_rready;

  assign axi.awid    = ID_WIDTH'(DATA_ID);
  assign axi.awaddr  = r_addr;
  assign axi.awlen   = LEN_SINGLE;
  assign axi.awsize  = SIZE_WORD;
  assign axi.awburst = BURST_INCR;
  assign axi.awcache = cache_attr(r_cache);
  assign axi.awvalid = w_awvalid;

  assign axi.wdata   = r_wdata;
  assign axi.wstrb   = r_wstrb;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = w_wvalid;
  assign axi.bready  = w_bready;

  assign o_data_rdata  = r_rdata;
  assign o_data_rvalid = w_data_rvalid;
  assign o_data_bvalid = w_data_bvalid;

endmodule
`default_nettype wire

// File: tb/tb_data_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_axi_bridge
// Purpose  : Self-checking bench for data_axi_bridge. A behavioural slave
//            with per-transaction wait counts drives the AXI side; expected
//            timing comes from the protocol rules (fixed pipeline plus wait
//            cycles), expected payload from the issued request.
// Revision : 1.0  initial release
// ============================================================================
module tb_data_axi_bridge;

  localparam int ID_W = 4;
  localparam int DID  = 1;

  logic        clk;
  logic        rst_n;
  logic        ren, wen, cached;
  logic [31:0] addr, wdata_in;
  logic [3:0]  wsel;
  logic [31:0] rdata_out;
  logic        rpulse, bpulse;

  int checks = 0;
  int errors = 0;

  data_axi_bridge_if #(.ID_WIDTH(ID_W)) axi ();

  data_axi_bridge #(.ID_WIDTH(ID_W), .DATA_ID(DID)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_data_ren     (ren),
    .i_data_wen     (wen),
    .i_data_addr    (addr),
    .i_data_wsel    (wsel),
    .i_data_wdata   (wdata_in),
    .i_cached_trans (cached),
    .o_data_rdata   (rdata_out),
    .o_data_rvalid  (rpulse),
    .o_data_bvalid  (bpulse),
    .axi            (axi.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
  endtask

  task automatic chk_all_quiet(input string tag);
    chk({tag, "_arvalid"}, axi.arvalid, 0);
    chk({tag, "_rready"},  axi.rready,  0);
    chk({tag, "_awvalid"}, axi.awvalid, 0);
    chk({tag, "_wvalid"},  axi.wvalid,  0);
    chk({tag, "_bready"},  axi.bready,  0);
    chk({tag, "_rpulse"},  rpulse,      0);
    chk({tag, "_bpulse"},  bpulse,      0);
  endtask

  // One read. Completion is expected at cycle 3 + ar_wait + r_wait after
  // the IDLE cycle that sees ren. rst_mid>0 aborts with an async reset once
  // the bridge is waiting for read data.
  task automatic do_read(input logic [31:0] a, input logic c_in, input int ar_wait,
                         input int r_wait, input logic [31:0] rd, input bit withdraw,
                         input bit rst_mid);
    int exp_done, ar_seen, r_seen;
    @(posedge clk); #1;
    chk_all_quiet("rd_idle");
    ren = 1'b1; wen = 1'b0; addr = a; cached = c_in;
    wsel = 4'($urandom); wdata_in = $urandom;
    exp_done = 3 + ar_wait + r_wait;
    ar_seen = 0; r_seen = 0;
    for (int c = 1; c <= exp_done; c++) begin
      @(posedge clk); #1;
      if (axi.arvalid) begin
        chk("araddr",  axi.araddr, a);
        chk("arcache", axi.arcache, c_in ? 32'hF : 32'h0);
        chk("arsize",  axi.arsize, 3'b010);
        chk("arlen",   axi.arlen, 0);
        chk("arburst", axi.arburst, 2'b01);
        chk("arid",    axi.arid, DID);
      end
      chk("rd_no_bpulse", bpulse, 0);
      chk("rd_no_aw", axi.awvalid, 0);
      if (c < exp_done) chk("rd_pulse_early", rpulse, 0);
      else              chk("rd_pulse", rpulse, !withdraw);
      slave_idle();
      axi.rdata = $urandom;
      if (axi.arvalid) begin
        if (ar_seen == ar_wait) axi.arready = 1'b1;
        ar_seen++;
      end
      if (axi.rready) begin
        if (rst_mid) begin
          #2 rst_n = 1'b0;
          #1;
          chk_all_quiet("rst_mid");
          chk("rst_mid_rdata", rdata_out, 0);
          ren = 1'b0;
          repeat (2) @(posedge clk);
          #1 rst_n = 1'b1;
          return;
        end
        if (r_seen == r_wait) begin
          axi.rvalid = 1'b1;
          axi.rdata  = rd;
        end
        r_seen++;
      end
      if (withdraw && c == 1) ren = 1'b0;
      if (rpulse) ren = 1'b0;
    end
    ren = 1'b0;
    chk("rd_ar_cycles", ar_seen, ar_wait + 1);
    chk("rd_r_cycles",  r_seen,  r_wait + 1);
    chk("rd_data",      rdata_out, rd);
  endtask

  // One write. AW and W are offered together from cycle 1; the address
  // phase lasts max(aw_wait, w_wait)+1 cycles, then b_wait+1 response
  // cycles, then the completion cycle.
  task automatic do_write(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd,
                          input logic c_in, input int aw_wait, input int w_wait,
                          input int b_wait, input bit withdraw);
    int exp_done, aw_seen, w_seen, b_seen, m;
    logic [31:0] rd_keep;
    @(posedge clk); #1;
    chk_all_quiet("wr_idle");
    rd_keep = rdata_out;
    ren = 1'b0; wen = 1'b1; addr = a; cached = c_in; wsel = ws; wdata_in = wd;
    m = (aw_wait > w_wait) ? aw_wait : w_wait;
    exp_done = 3 + m + b_wait;
    aw_seen = 0; w_seen = 0; b_seen = 0;
    for (int c = 1; c <= exp_done; c++) begin
      @(posedge clk); #1;
      if (axi.awvalid) begin
        chk("awaddr",  axi.awaddr, a);
        chk("awcache", axi.awcache, c_in ? 32'hF : 32'h0);
        chk("awsize",  axi.awsize, 3'b010);
        chk("awlen",   axi.awlen, 0);
        chk("awburst", axi.awburst, 2'b01);
        chk("awid",    axi.awid, DID);
      end
      if (axi.wvalid) begin
        chk("wdata", axi.wdata, wd);
        chk("wstrb", axi.wstrb, ws);
        chk("wlast", axi.wlast, 1);
      end
      chk("wr_no_rpulse", rpulse, 0);
      chk("wr_no_ar", axi.arvalid, 0);
      if (c < exp_done) chk("wr_pulse_early", bpulse, 0);
      else              chk("wr_pulse", bpulse, !withdraw);
      slave_idle();
      if (axi.awvalid) begin
        if (aw_seen == aw_wait) axi.awready = 1'b1;
        aw_seen++;
      end
      if (axi.wvalid) begin
        if (w_seen == w_wait) axi.wready = 1'b1;
        w_seen++;
      end
      if (axi.bready) begin
        if (b_seen == b_wait) axi.bvalid = 1'b1;
        b_seen++;
      end
      if (withdraw && c == 1) wen = 1'b0;
      if (bpulse) wen = 1'b0;
    end
    wen = 1'b0;
    chk("wr_aw_cycles", aw_seen, aw_wait + 1);
    chk("wr_w_cycles",  w_seen,  w_wait + 1);
    chk("wr_b_cycles",  b_seen,  b_wait + 1);
    chk("wr_rdata_hold", rdata_out, rd_keep);
  endtask

  initial begin
    logic [31:0] ra, rv;
    rst_n = 1'b0;
    ren = 1'b0; wen = 1'b0; cached = 1'b0;
    addr = 32'd0; wsel = 4'd0; wdata_in = 32'd0;
    slave_idle();
    axi.rdata = 32'd0; axi.rid = '0; axi.rresp = 2'b00; axi.rlast = 1'b1;
    axi.bid = '0; axi.bresp = 2'b00;

    // Reset state
    #1;
    chk_all_quiet("reset");
    chk("reset_rdata",  rdata_out, 0);
    chk("reset_araddr", axi.araddr, 0);
    chk("reset_wdata",  axi.wdata, 0);
    chk("reset_wstrb",  axi.wstrb, 0);
    chk("reset_cache",  axi.arcache, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Zero-wait read: pulse exactly at cycle 3
    do_read(32'h8000_0010, 1'b1, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // Staggered write: awready at +1, wready at +4, bvalid at +6
    do_write(32'h8000_0100, 4'b0100, 32'h5A5A_5A5A, 1'b1, 0, 3, 1, 1'b0);

    // Back-to-back load then store, zero-wait slave
    do_read(32'h0000_0040, 1'b0, 0, 0, 32'h1234_5678, 1'b0, 1'b0);
    do_write(32'h0000_0044, 4'b1111, 32'hCAFE_F00D, 1'b0, 0, 0, 0, 1'b0);

    // Withdrawal during a 3-cycle AR stall, then a normal read
    do_read(32'h1000_0000, 1'b1, 3, 0, 32'hAAAA_5555, 1'b1, 1'b0);
    do_read(32'h1000_0004, 1'b1, 0, 1, 32'h0BAD_CAFE, 1'b0, 1'b0);

    // Cache attribute both ways
    do_read(32'h2000_0000, 1'b0, 1, 0, 32'h0000_0001, 1'b0, 1'b0);
    do_read(32'h2000_0004, 1'b1, 0, 2, 32'h8000_0000, 1'b0, 1'b0);

    // Write withdrawal and same-cycle AW/W with response wait
    do_write(32'h3000_0000, 4'b0011, 32'h1111_2222, 1'b0, 2, 1, 2, 1'b1);
    do_write(32'h3000_0008, 4'b1000, 32'h3333_4444, 1'b1, 2, 2, 0, 1'b0);

    // Randomized mix
    for (int n = 0; n < 40; n++) begin
      ra = $urandom & 32'hFFFF_FFFC;
      rv = $urandom;
      if ($urandom_range(0, 1) == 0)
        do_read(ra, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), rv,
                ($urandom_range(0, 5) == 0), 1'b0);
      else
        do_write(ra, 4'($urandom), rv, 1'($urandom), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
    end

    // Async reset while waiting in RD_DATA, then normal service from IDLE
    do_read(32'h4000_0000, 1'b1, 0, 3, 32'h7777_7777, 1'b0, 1'b1);
    slave_idle();
    do_read(32'h4000_0010, 1'b0, 0, 0, 32'h0F0F_0F0F, 1'b0, 1'b0);
    do_write(32'h4000_0014, 4'b0001, 32'h0101_0101, 1'b1, 1, 0, 0, 1'b0);

    @(posedge clk); #1;
    chk_all_quiet("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
